sext_unit_pipe: RTL and testbench
=================================

Name: sext_unit_pipe

Overview:
- Parametrised, buffered immediate/offset generator for the LC-3 datapath.
- Extracts the field selected by `mode` from a 16-bit instruction word:
  - imm5, offset6, PCoffset9 and PCoffset11 are sign-extended.
  - trapvect8 is zero-extended.
- Result is DATA_W bits wide and held in a DEPTH-entry elastic FIFO with valid/ready handshakes on both sides.
- Sits between the IR/decode stage and the address adder / ALU B-mux, decoupling decode from execute stalls.

Parameters:
- DATA_W, 16, output width; legal range 16..32. At elaboration, a value below 16 must raise a fatal error.
- DEPTH, 2, number of output FIFO entries; power of two, 2..8.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a request on `ir`/`mode`.
- in_ready  out  1  unit can accept a request this cycle.
- ir  in  16  instruction word.
- mode  in  3  field select: 0=imm5 ir[4:0], 1=offset6 ir[5:0], 2=PCoffset9 ir[8:0], 3=PCoffset11 ir[10:0], 4=trapvect8 ir[7:0], 5..7=illegal.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  consumer takes the head this cycle.
- out_data  out  DATA_W  extended result at the FIFO head.
- out_err  out  1  head entry came from an illegal mode.
- occupancy  out  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Reset: asynchronous, active-high (Reset=1 clears immediately, independent of Clk).
  - Clears read pointer, write pointer, occupancy and every entry.
  - Outputs during and after reset: out_valid=0, out_data=0, out_err=0, occupancy=0, in_ready=1 (after release).
- Reset mid-operation discards all buffered entries; no partial result survives.
- Push: occurs when in_valid && in_ready on a rising Clk.
  - Extension is computed combinationally from ir/mode and written into entry[wr_ptr].
- Extension rules:
  - Sign modes replicate the field MSB into bits [DATA_W-1 : field width].
  - Mode 4 fills the upper bits with zeros.
  - Illegal modes write data=0 and err=1; all legal modes write err=0.
- in_ready = (occupancy < DEPTH). It is combinational from registered occupancy only; it does not depend on out_ready.
- Full and popping in the same cycle: in_ready stays 0, so there is no push that cycle. Accepted bubble; no bypass.
- Pop: occurs when out_valid && out_ready on a rising Clk; rd_ptr advances.
- out_valid = (occupancy != 0).
- out_data and out_err are taken from entry[rd_ptr]. They are held stable while out_valid && !out_ready.
- Latency: a request accepted at edge N is visible at the head no earlier than after edge N, i.e. out_valid is observed in the cycle after N when the FIFO was empty. There is no combinational in→out path.
- Ordering: strict FIFO.
- Pointers wrap modulo DEPTH; occupancy never exceeds DEPTH or drops below 0.
- Simultaneous push and pop when 0 < occupancy < DEPTH: occupancy is unchanged and both pointers advance.
- Push into an empty FIFO with out_ready=1: no pop that cycle, because out_valid was 0. The entry is popped on a later edge.
- When out_valid=0, out_data and out_err show the stale entry[rd_ptr]. Consumers must qualify them with out_valid.

Optional Feature:
- Macro: SEXT_BYTE_ADDR_EN.
- Defined:
  - Adds input port `byte_addr` (1 bit), sampled with `ir` on push.
  - When 1 and mode is 1..3, the extended value is shifted left by 1 and truncated to DATA_W; bit 0 is 0.
  - Modes 0, 4 and illegal modes are never shifted.
  - The shift is applied before the FIFO write, so latency is unchanged.
- Not defined: the port does not exist and no shift is performed.

Test Plan:
- Reset, then push mode=0 with ir=16'h001F → one cycle later out_valid=1, out_data=16'hFFFF, out_err=0. Then push mode=0 with ir=16'h000F → out_data=16'h000F.
- DATA_W=32: mode=3 with ir=16'h0400 → out_data=32'hFFFFFC00. mode=4 with ir=16'h00FF → 32'h000000FF. mode=2 with ir=16'h00FF → 32'h000000FF.
- mode=6 → out_data=0, out_err=1. A following mode=1 with ir=16'h0020 → out_data=16'hFFE0, out_err=0.
- DEPTH=2, out_ready=0, push 3 requests back-to-back:
  - After 2 pushes, occupancy=2 and in_ready=0; the third request is held.
  - Raise out_ready → results come out in order.
  - The held request enters one cycle after the first pop; occupancy never exceeds 2.
- Streaming with out_ready=1 and in_valid=1 for 20 cycles of random modes → every result matches the reference model, in order, with no loss and no duplication.
- Assert Reset asynchronously (between clock edges) while occupancy=2 → out_valid=0 and occupancy=0 immediately. Old entries never appear after release.
- With SEXT_BYTE_ADDR_EN, mode=2, ir=16'h0100, byte_addr=1 → out_data=16'hFE00.

Source files
------------

// File: rtl/sext_unit_pipe.sv
// LC-3 immediate/offset extender feeding a DEPTH-entry elastic FIFO.
// Optional macro SEXT_BYTE_ADDR_EN adds byte_addr (left-shift of offsets).
module sext_unit_pipe #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              ir,
  input  logic [2:0]               mode,
`ifdef SEXT_BYTE_ADDR_EN
  input  logic                     byte_addr,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DATA_W < 16) begin : g_bad_width
    $fatal(1, "sext_unit_pipe: DATA_W must be at least 16");
  end
  if (DATA_W > 32) begin : g_wide_width
    $fatal(1, "sext_unit_pipe: DATA_W must be at most 32");
  end
  if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "sext_unit_pipe: DEPTH must be a power of two in 2..8");
  end

  logic [DATA_W-1:0] data_q [DEPTH];
  logic              err_q  [DEPTH];
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [DATA_W-1:0] sx;
  logic [DATA_W-1:0] ext;
  logic              ext_err;
  logic              push;
  logic              pop;
  logic              shift_en;

  always_comb begin
    sx      = '0;
    ext_err = 1'b0;
    case (mode)
      3'd0:    sx = {{(DATA_W-5){ir[4]}}, ir[4:0]};
      3'd1:    sx = {{(DATA_W-6){ir[5]}}, ir[5:0]};
      3'd2:    sx = {{(DATA_W-9){ir[8]}}, ir[8:0]};
      3'd3:    sx = {{(DATA_W-11){ir[10]}}, ir[10:0]};
      3'd4:    sx = {{(DATA_W-8){1'b0}}, ir[7:0]};
      default: ext_err = 1'b1;
    endcase
  end

  // Only the memory offsets (modes 1..3) are ever scaled to byte addresses.
  always_comb begin
    shift_en = 1'b0;
`ifdef SEXT_BYTE_ADDR_EN
    shift_en = byte_addr && (mode == 3'd1 || mode == 3'd2 || mode == 3'd3);
`endif
    ext = shift_en ? {sx[DATA_W-2:0], 1'b0} : sx;
  end

  assign in_ready  = (cnt_q < CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      wr_d = wr_q + PW'(1);
    end
    if (pop) begin
      rd_d = rd_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        err_q[i]  <= 1'b0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push) begin
        data_q[wr_q] <= ext_err ? '0 : ext;
        err_q[wr_q]  <= ext_err;
      end
    end
  end

  assign out_data  = data_q[rd_q];
  assign out_err   = err_q[rd_q];
  assign occupancy = cnt_q;

endmodule

// File: tb/tb_sext_unit_pipe.sv
// Directed bench for sext_unit_pipe: 16-bit/2-deep and 32-bit/4-deep builds.
// Covers extension rules, backpressure, streaming order and async reset.
module tb_sext_unit_pipe;

  logic        Clk;
  logic        Reset;
  logic        ba;

  logic        va, ra, ova, ora, ea;
  logic [15:0] ira, da;
  logic [2:0]  ma;
  logic [1:0]  occa;

  logic        vb, rb, ovb, orb, eb;
  logic [15:0] irb;
  logic [31:0] db;
  logic [2:0]  mb;
  logic [2:0]  occb;

  int n_cmp;
  int n_err;

  sext_unit_pipe #(.DATA_W(16), .DEPTH(2)) u_a (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (va),
    .in_ready  (ra),
    .ir        (ira),
    .mode      (ma),
`ifdef SEXT_BYTE_ADDR_EN
    .byte_addr (ba),
`endif
    .out_valid (ova),
    .out_ready (ora),
    .out_data  (da),
    .out_err   (ea),
    .occupancy (occa)
  );

  sext_unit_pipe #(.DATA_W(32), .DEPTH(4)) u_b (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (vb),
    .in_ready  (rb),
    .ir        (irb),
    .mode      (mb),
`ifdef SEXT_BYTE_ADDR_EN
    .byte_addr (ba),
`endif
    .out_valid (ovb),
    .out_ready (orb),
    .out_data  (db),
    .out_err   (eb),
    .occupancy (occb)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pa(input string tag, input logic [15:0] r,
                    input logic [2:0] m, input logic [15:0] ed,
                    input logic ee);
    va = 1'b1; ira = r; ma = m;
    tick();
    va = 1'b0;
    chk({tag, "_valid"}, 32'(ova), 32'd1);
    chk({tag, "_data"}, 32'(da), 32'(ed));
    chk({tag, "_err"}, 32'(ea), 32'(ee));
    ora = 1'b1;
    tick();
    ora = 1'b0;
    chk({tag, "_drain"}, 32'(occa), 32'd0);
  endtask

  task automatic pb(input string tag, input logic [15:0] r,
                    input logic [2:0] m, input logic [31:0] ed,
                    input logic ee);
    vb = 1'b1; irb = r; mb = m;
    tick();
    vb = 1'b0;
    chk({tag, "_valid"}, 32'(ovb), 32'd1);
    chk({tag, "_data"}, db, ed);
    chk({tag, "_err"}, 32'(eb), 32'(ee));
    orb = 1'b1;
    tick();
    orb = 1'b0;
    chk({tag, "_drain"}, 32'(occb), 32'd0);
  endtask

  function automatic logic [31:0] mdl(input logic [15:0] r,
                                      input logic [2:0] m,
                                      input logic b, input int w);
    int nb;
    logic [31:0] v, msk;
    case (m)
      3'd0: nb = 5;
      3'd1: nb = 6;
      3'd2: nb = 9;
      3'd3: nb = 11;
      3'd4: nb = 8;
      default: nb = 0;
    endcase
    if (nb == 0) return 32'd0;
    msk = (32'd1 << nb) - 32'd1;
    v = {16'd0, r} & msk;
    if (m != 3'd4 && v[nb-1]) v = v | ~msk;
`ifdef SEXT_BYTE_ADDR_EN
    if (b && m >= 3'd1 && m <= 3'd3) v = v << 1;
`else
    if (b && 1'b0) v = v << 1;
`endif
    if (w < 32) v = v & ((32'd1 << w) - 32'd1);
    return v;
  endfunction

  initial begin
    logic [16:0] q[$];
    logic [16:0] e;
    logic [15:0] r;
    logic [2:0]  m;
    logic        push_now, pop_now;
    int          npush;

    n_cmp = 0; n_err = 0; npush = 0;
    Reset = 1'b1; ba = 1'b0;
    va = 0; ora = 0; ira = '0; ma = '0;
    vb = 0; orb = 0; irb = '0; mb = '0;

    #2;
    chk("rst_valid", 32'(ova), 32'd0);
    chk("rst_data", 32'(da), 32'd0);
    chk("rst_err", 32'(ea), 32'd0);
    chk("rst_occ", 32'(occa), 32'd0);
    tick();
    Reset = 1'b0;
    #1;
    chk("rel_ready_a", 32'(ra), 32'd1);
    chk("rel_ready_b", 32'(rb), 32'd1);

    pa("m0_neg", 16'h001F, 3'd0, 16'hFFFF, 1'b0);
    pa("m0_pos", 16'h000F, 3'd0, 16'h000F, 1'b0);
    pa("m6_ill", 16'hFFFF, 3'd6, 16'h0000, 1'b1);
    pa("m1_neg", 16'h0020, 3'd1, 16'hFFE0, 1'b0);
    pa("m1_pos", 16'h001F, 3'd1, 16'h001F, 1'b0);
    pa("m3_neg", 16'h07FF, 3'd3, 16'hFFFF, 1'b0);
    pa("m4_zx", 16'hFF80, 3'd4, 16'h0080, 1'b0);
    pa("m5_ill", 16'h1234, 3'd5, 16'h0000, 1'b1);

`ifdef SEXT_BYTE_ADDR_EN
    ba = 1'b1;
    pa("ba_m2", 16'h0100, 3'd2, 16'hFE00, 1'b0);
    pa("ba_m0", 16'h001F, 3'd0, 16'hFFFF, 1'b0);
    pa("ba_m4", 16'h00FF, 3'd4, 16'h00FF, 1'b0);
    ba = 1'b0;
`else
    pa("m2_neg", 16'h0100, 3'd2, 16'hFF00, 1'b0);
`endif

    pb("w_m3", 16'h0400, 3'd3, 32'hFFFFFC00, 1'b0);
    pb("w_m4", 16'h00FF, 3'd4, 32'h000000FF, 1'b0);
    pb("w_m2", 16'h00FF, 3'd2, 32'h000000FF, 1'b0);
    pb("w_m0", 16'h0010, 3'd0, 32'hFFFFFFF0, 1'b0);
    pb("w_m7", 16'hFFFF, 3'd7, 32'h00000000, 1'b1);

    // push into empty with out_ready high: no same-cycle pop
    ora = 1'b1; va = 1'b1; ira = 16'h0005; ma = 3'd0;
    tick();
    va = 1'b0;
    chk("empty_push_occ", 32'(occa), 32'd1);
    chk("empty_push_data", 32'(da), 32'h0005);
    tick();
    chk("empty_push_pop", 32'(occa), 32'd0);
    ora = 1'b0;

    // backpressure on the 2-deep instance
    va = 1'b1; ira = 16'h0001; ma = 3'd0;
    tick();
    chk("bp_occ1", 32'(occa), 32'd1);
    ira = 16'h0002;
    tick();
    chk("bp_occ2", 32'(occa), 32'd2);
    chk("bp_full", 32'(ra), 32'd0);
    ira = 16'h0003;
    tick();
    chk("bp_hold_occ", 32'(occa), 32'd2);
    chk("bp_head1", 32'(da), 32'h0001);
    ora = 1'b1;
    tick();
    chk("bp_pop_occ", 32'(occa), 32'd1);
    chk("bp_head2", 32'(da), 32'h0002);
    chk("bp_ready", 32'(ra), 32'd1);
    tick();
    va = 1'b0;
    chk("bp_pushpop_occ", 32'(occa), 32'd1);
    chk("bp_head3", 32'(da), 32'h0003);
    tick();
    chk("bp_empty", 32'(occa), 32'd0);

    // streaming against the model
    for (int i = 0; i < 20; i++) begin
      r = 16'($urandom);
      m = 3'($urandom_range(0, 7));
      va = 1'b1; ira = r; ma = m;
      push_now = ra;
      pop_now  = ova;
      if (pop_now) begin
        if (q.size() == 0) begin
          chk("stream_dup", 32'(ova), 32'd0);
        end else begin
          e = q.pop_front();
          chk("stream_data", 32'(da), 32'(e[15:0]));
          chk("stream_err", 32'(ea), 32'(e[16]));
        end
      end
      tick();
      if (push_now) begin
        npush++;
        q.push_back({(m > 3'd4), mdl(r, m, ba, 16)[15:0]});
      end
    end
    va = 1'b0;
    for (int i = 0; i < 8 && ova; i++) begin
      if (q.size() == 0) begin
        chk("stream_dup", 32'(ova), 32'd0);
      end else begin
        e = q.pop_front();
        chk("stream_data", 32'(da), 32'(e[15:0]));
        chk("stream_err", 32'(ea), 32'(e[16]));
      end
      tick();
    end
    chk("stream_pushes", 32'(npush), 32'd20);
    chk("stream_left", 32'(q.size()), 32'd0);
    chk("stream_idle", 32'(ova), 32'd0);
    ora = 1'b0;

    // asynchronous reset while full
    va = 1'b1; ira = 16'h0011; ma = 3'd0;
    tick();
    ira = 16'h0012;
    tick();
    va = 1'b0;
    chk("ar_full", 32'(occa), 32'd2);
    #2;
    Reset = 1'b1;
    #1;
    chk("ar_valid", 32'(ova), 32'd0);
    chk("ar_occ", 32'(occa), 32'd0);
    chk("ar_data", 32'(da), 32'd0);
    tick();
    Reset = 1'b0;
    #1;
    chk("ar_rel_valid", 32'(ova), 32'd0);
    ora = 1'b1;
    tick();
    chk("ar_no_ghost", 32'(ova), 32'd0);
    ora = 1'b0;
    pa("ar_fresh", 16'h0003, 3'd0, 16'h0003, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
